// File: rtl/seg7_pkg.sv
// seg7_pkg: scan FSM state type and active-low {g,f,e,d,c,b,a} segment patterns
package seg7_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to segment pattern; non-decimal nibbles show a dash
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = (digit_i > 4'd9) ? DASH : DIGIT_SEG[digit_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: captures a BCD product on the finish rising edge and multiplexes it onto a 7-seg display.
// Define LEADING_ZERO_BLANK_EN to keep digits above the most significant nonzero digit dark.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N = 8,
  parameter int SCAN_DIV = 1000,
  localparam int DIGITS = ((2*N)/3)+1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                finish,
  input  logic [DIGITS*4-1:0] bcd,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                loaded,
  output logic                bcd_err
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS*4-1:0] shadow_q;
  logic [6:0] seg_q, seg_d, dec_seg;
  logic [DIGITS-1:0] an_q, an_d;
  logic finish_q, armed_q, loaded_q, err_q;
  logic capture, wrap, bad, digit_on;
  // armed_q blocks a capture from finish that was already high when reset released
  assign capture = finish & ~finish_q & armed_q;
  assign wrap = presc_q == PW'(SCAN_DIV-1);
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) bad = bad | (bcd[4*k +: 4] > 4'd9);
  end
  bcd_to_seg7 u_dec (
    .digit_i(shadow_q[{idx_q, 2'b00} +: 4]),
    .seg_o  (dec_seg)
  );
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int k = 1; k < DIGITS; k++) msd = (shadow_q[4*k +: 4] != 4'd0) ? IW'(k) : msd;
  end
  assign digit_on = idx_q <= msd;
`else
  assign digit_on = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    idx_d = '0;
    seg_d = BLANK;
    an_d = '1;
    if (state_q == IDLE) begin
      state_d = capture ? SCAN : IDLE;
    end else begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
      idx_d = !wrap ? idx_q : (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
      seg_d = dec_seg;
      an_d = digit_on ? ~(DIGITS'(1) << idx_q) : '1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      finish_q <= 1'b0;
      armed_q <= 1'b0;
      seg_q <= BLANK;
      an_q <= '1;
      loaded_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      finish_q <= finish;
      armed_q <= armed_q | ~finish;
      seg_q <= seg_d;
      an_q <= an_d;
      if (capture) begin
        shadow_q <= bcd;
        loaded_q <= 1'b1;
        err_q <= bad;
      end
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign loaded = loaded_q;
  assign bcd_err = err_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of capture, scanning, error flag and reset behaviour (N=8, SCAN_DIV=4)
module tb_seg7_scan_driver;
  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P5 = 7'b0010010, P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000, P8 = 7'b0000000, PD = 7'b0111111, PB = 7'h7F;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic finish = 1'b0;
  logic [23:0] bcd = '0;
  logic [6:0] seg;
  logic [5:0] an;
  logic loaded, bcd_err;
  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] slot_seg [6] = '{P0, P8, P7, P0, P0, P0};
  logic [5:0] exp_an;
  seg7_scan_driver #(.N(8), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .finish(finish), .bcd(bcd),
    .seg(seg), .an(an), .loaded(loaded), .bcd_err(bcd_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    check("rst_an", 32'(an), 32'h3F);
    check("rst_seg", 32'(seg), 32'(PB));
    check("rst_loaded", 32'(loaded), 0);
    check("rst_err", 32'(bcd_err), 0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_an", 32'(an), 32'h3F);
      check("idle_seg", 32'(seg), 32'(PB));
      check("idle_loaded", 32'(loaded), 0);
    end
    bcd = 24'h000780;
    finish = 1'b1;
    tick();
    check("cap_loaded", 32'(loaded), 1);
    check("cap_an_blank", 32'(an), 32'h3F);
    check("cap_err", 32'(bcd_err), 0);
    finish = 1'b0;
    bcd = 24'h999999;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = (s < 3) ? ~(6'd1 << s) : 6'h3F;
`else
        exp_an = ~(6'd1 << s);
`endif
        check("scan_an", 32'(an), 32'(exp_an));
        if (exp_an != 6'h3F) check("scan_seg", 32'(seg), 32'(slot_seg[s]));
      end
    end
    repeat (4) tick();
    bcd = 24'h000169;
    finish = 1'b1;
    tick();
    check("mid_an_keep", 32'(an), 32'h3D);
    check("mid_seg_old", 32'(seg), 32'(P8));
    finish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_an", 32'(an), 32'h3D);
      check("mid_seg_new", 32'(seg), 32'(P6));
    end
    check("mid_err", 32'(bcd_err), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d2_an", 32'(an), 32'h3B);
      check("d2_seg", 32'(seg), 32'(P1));
    end
    bcd = 24'h00A123;
    finish = 1'b1;
    tick();
    check("same_edge_an", 32'(an), 32'h3B);
    check("same_edge_seg", 32'(seg), 32'(P1));
    check("err_set", 32'(bcd_err), 1);
    finish = 1'b0;
    tick();
    check("dash_an", 32'(an), 32'h37);
    check("dash_seg", 32'(seg), 32'(PD));
    bcd = 24'h000042;
    finish = 1'b1;
    tick();
    check("err_clear", 32'(bcd_err), 0);
    check("clear_an_keep", 32'(an), 32'h37);
    finish = 1'b0;
    tick();
    reset = 1'b1;
    finish = 1'b1;
    bcd = 24'h000555;
    tick();
    check("mrst_an", 32'(an), 32'h3F);
    check("mrst_seg", 32'(seg), 32'(PB));
    check("mrst_loaded", 32'(loaded), 0);
    check("mrst_err", 32'(bcd_err), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_loaded", 32'(loaded), 0);
      check("held_an", 32'(an), 32'h3F);
    end
    finish = 1'b0;
    tick();
    check("low_loaded", 32'(loaded), 0);
    finish = 1'b1;
    tick();
    check("recap_loaded", 32'(loaded), 1);
    tick();
    check("recap_an", 32'(an), 32'h3E);
    check("recap_seg", 32'(seg), 32'(P5));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N, default 8: operand width of the upstream multiplier.
REQ-002 Parameter DIGITS, default ((2*N)/3)+1 (6 for N=8): number of BCD digits, derived and not overridden.
REQ-003 Parameter SCAN_DIV, default 1000, legal range >=1: clock cycles each digit is displayed.
REQ-004 clk  in  1  rising-edge clock for the whole block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 finish  in  1  level "product ready" from the multiplier; its rising edge is the load strobe.
REQ-007 bcd  in  DIGITS*4  packed BCD product; digit k is bcd[4k+3:4k], digit 0 least significant.
REQ-008 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 an  out  DIGITS  active-low digit enables, at most one low.
REQ-010 loaded  out  1  high once a product has been captured.
REQ-011 bcd_err  out  1  sticky flag: captured value contains a nibble >9.

Function
REQ-012 The block SHALL register finish into finish_q and detect capture as finish=1 and finish_q=0.
REQ-013 On capture, the block SHALL copy bcd into a shadow register on that edge; later changes on bcd SHALL be ignored until the next capture.
REQ-014 FSM states SHALL be IDLE and SCAN; IDLE->SCAN on first capture; SCAN has no exit except reset.
REQ-015 In IDLE, prescaler and digit index SHALL stay at 0, an SHALL be all ones, and seg SHALL be 7'h7F.
REQ-016 In SCAN, the prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL return to 0 and the index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-017 SCAN_DIV=1 SHALL advance the index every cycle.
REQ-018 seg and an SHALL be registered, reflecting the index and shadow value one cycle after they change.
REQ-019 Decode patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibbles 10-15 SHALL show a dash (0111111).
REQ-020 bcd_err SHALL be set on a capture whose value has any nibble >9, and cleared on a capture whose value has none.
REQ-021 A capture during SCAN SHALL update the shadow without disturbing the prescaler or index.
REQ-022 When a capture and an index advance fall on the same edge, the next displayed digit SHALL come from the new shadow value.
REQ-023 loaded SHALL rise on the first capture edge and stay high until reset.

Reset
REQ-024 When reset is high at a clock edge, these SHALL take effect on that edge, overriding a simultaneous capture:
- state=IDLE; prescaler=0; index=0; shadow=0; finish_q=0
- seg=7'h7F; an=all ones; loaded=0; bcd_err=0
REQ-025 Reset during SCAN SHALL blank the display from the next edge, and finish held high through reset release SHALL NOT cause a capture until it falls and rises again.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero shadow digit SHALL have their an bit held high; digit 0 SHALL always be enabled.
REQ-027 Macro LEADING_ZERO_BLANK_EN undefined: all DIGITS digits SHALL be enabled in turn, including leading zeros.

Structure
REQ-028 Package seg7_pkg SHALL hold the FSM state typedef, the ten digit patterns, and the BLANK and DASH constants.
REQ-029 The combinational nibble-to-pattern decoder SHALL be the sub-module bcd_to_seg7; all sequential logic SHALL stay in seg7_scan_driver.

Verification (N=8, DIGITS=6, SCAN_DIV=4)
REQ-030 Reset, then no finish for 50 cycles -> an=6'b111111, seg=7'h7F, loaded=0 throughout.
REQ-031 bcd=24'h000780 with a finish rise (26*30), macro off -> an cycles 111110,111101,...,011111 every 4 cycles; seg shows 0 (1000000), 8, 7, then 0,0,0.
REQ-032 Same stimulus, macro on -> only digits 0-2 enabled; an high during slots 3-5; seg correct for 0, 8, 7.
REQ-033 Mid-scan, bcd=24'h000169 with a finish rise (13*13) -> index is not reset; next slot shows the new digit; bcd_err=0.
REQ-034 bcd=24'h00A123 with a finish rise -> bcd_err=1; digit 3 shows 0111111; a later valid capture clears bcd_err.
REQ-035 Reset asserted mid-scan with finish held high -> blank on the next edge; no capture until finish falls and rises again.
